// File: rtl/axil_slave_pkg.sv
// Shared types for the AXI4-Lite register-file slave: response codes,
// FSM state encodings and the register-index width helper.
package axil_slave_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } rd_state_t;

  // Bits needed to index NUM_REGS registers; never narrower than one bit.
  function automatic int idx_width(input int num_regs);
    return (num_regs > 2) ? $clog2(num_regs) : 1;
  endfunction

endpackage

// File: rtl/axil_regfile_core.sv
// Register storage: one byte-strobed write port, one combinational read
// port and the flattened contents of every register.
module axil_regfile_core
  import axil_slave_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int IDXW     = idx_width(NUM_REGS)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         we_i,
  input  logic [IDXW-1:0]              widx_i,
  input  logic [DATA_WIDTH-1:0]        wdata_i,
  input  logic [STRB_WIDTH-1:0]        wstrb_i,
  input  logic [IDXW-1:0]              ridx_i,
  output logic [DATA_WIDTH-1:0]        rdata_o,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  always_comb begin
    regs_d = regs_q;
    if (we_i) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (wstrb_i[b]) regs_d[widx_i][8*b +: 8] = wdata_i[8*b +: 8];
      end
    end
  end

  // Reset wins over a same-edge write, so an aborted transaction never lands.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rdata_o = regs_q[ridx_i];

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_o[DATA_WIDTH*g +: DATA_WIDTH] = regs_q[g];
  end

endmodule

// File: rtl/axil_slave_regfile.sv
// AXI4-Lite slave terminating writes and reads into a bank of 32-bit
// registers; write and read channels run independent two-state FSMs.
module axil_slave_regfile
  import axil_slave_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int NUM_REGS   = 16
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic [ADDR_WIDTH-1:0]          s_axil_awaddr,
  input  logic [2:0]                     s_axil_awprot,
  input  logic                           s_axil_awvalid,
  output logic                           s_axil_awready,
  input  logic [DATA_WIDTH-1:0]          s_axil_wdata,
  input  logic [STRB_WIDTH-1:0]          s_axil_wstrb,
  input  logic                           s_axil_wvalid,
  output logic                           s_axil_wready,
  output logic [1:0]                     s_axil_bresp,
  output logic                           s_axil_bvalid,
  input  logic                           s_axil_bready,
  input  logic [ADDR_WIDTH-1:0]          s_axil_araddr,
  input  logic [2:0]                     s_axil_arprot,
  input  logic                           s_axil_arvalid,
  output logic                           s_axil_arready,
  output logic [DATA_WIDTH-1:0]          s_axil_rdata,
  output logic [1:0]                     s_axil_rresp,
  output logic                           s_axil_rvalid,
  input  logic                           s_axil_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  output wr_state_t                      wr_state_o,
  output rd_state_t                      rd_state_o
);

  localparam int IDXW = idx_width(NUM_REGS);

  // Handshake rule on every channel: a beat transfers on the rising edge
  // where valid && ready; all readies and valids driven here are registered.

  function automatic logic in_range(input logic [ADDR_WIDTH-3:0] word_addr);
    return 32'(word_addr) < 32'(NUM_REGS);
  endfunction

  // ---------------- write channel ----------------
  wr_state_t               wr_state_q, wr_state_d;
  logic                    awready_q, awready_d;
  logic                    wready_q, wready_d;
  logic                    aw_held_q, aw_held_d;
  logic                    w_held_q, w_held_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
  logic                    bvalid_q, bvalid_d;
  resp_t                   bresp_q, bresp_d;

  logic                    aw_fire, w_fire, have_aw, have_w;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [STRB_WIDTH-1:0]   wr_strb;
  logic                    wr_en;

  assign aw_fire = s_axil_awvalid && awready_q;
  assign w_fire  = s_axil_wvalid && wready_q;
  assign have_aw = aw_held_q || aw_fire;
  assign have_w  = w_held_q || w_fire;
  assign wr_addr = aw_held_q ? awaddr_q : s_axil_awaddr;
  assign wr_data = w_held_q ? wdata_q : s_axil_wdata;
  assign wr_strb = w_held_q ? wstrb_q : s_axil_wstrb;

  always_comb begin
    wr_state_d = wr_state_q;
    awready_d  = awready_q;
    wready_d   = wready_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    wr_en      = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        if (have_aw && have_w) begin
          wr_state_d = W_RESP;
          awready_d  = 1'b0;
          wready_d   = 1'b0;
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
          bvalid_d   = 1'b1;
          if (in_range(wr_addr[ADDR_WIDTH-1:2])) begin
            wr_en   = 1'b1;
            bresp_d = OKAY;
          end else begin
            bresp_d = SLVERR;
          end
        end else begin
          // Only one of AW/W so far: park it and stop accepting that channel.
          awready_d = !have_aw;
          wready_d  = !have_w;
          aw_held_d = have_aw;
          w_held_d  = have_w;
          if (aw_fire) awaddr_d = s_axil_awaddr;
          if (w_fire) begin
            wdata_d = s_axil_wdata;
            wstrb_d = s_axil_wstrb;
          end
        end
      end
      W_RESP: begin
        if (s_axil_bready) begin
          wr_state_d = W_IDLE;
          bvalid_d   = 1'b0;
          awready_d  = 1'b1;
          wready_d   = 1'b1;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_state_q <= W_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= OKAY;
    end else begin
      wr_state_q <= wr_state_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
    end
  end

  // ---------------- read channel ----------------
  rd_state_t             rd_state_q, rd_state_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  resp_t                 rresp_q, rresp_d;
  logic                  ar_fire;
  logic [DATA_WIDTH-1:0] core_rdata;

  assign ar_fire = s_axil_arvalid && arready_q;

  always_comb begin
    rd_state_d = rd_state_q;
    arready_d  = arready_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    case (rd_state_q)
      R_IDLE: begin
        if (ar_fire) begin
          rd_state_d = R_RESP;
          arready_d  = 1'b0;
          rvalid_d   = 1'b1;
          if (in_range(s_axil_araddr[ADDR_WIDTH-1:2])) begin
            rdata_d = core_rdata;
            rresp_d = OKAY;
          end else begin
            rdata_d = '0;
            rresp_d = SLVERR;
          end
        end else begin
          arready_d = 1'b1;
        end
      end
      R_RESP: begin
        if (s_axil_rready) begin
          rd_state_d = R_IDLE;
          rvalid_d   = 1'b0;
          arready_d  = 1'b1;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= OKAY;
    end else begin
      rd_state_q <= rd_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  // Read port samples pre-edge storage, so a same-edge write is not seen.
  axil_regfile_core #(
    .NUM_REGS (NUM_REGS),
    .IDXW     (IDXW)
  ) u_core (
    .clk_i   (aclk),
    .rst_i   (areset),
    .we_i    (wr_en),
    .widx_i  (wr_addr[IDXW+1:2]),
    .wdata_i (wr_data),
    .wstrb_i (wr_strb),
    .ridx_i  (s_axil_araddr[IDXW+1:2]),
    .rdata_o (core_rdata),
    .regs_o  (regs_o)
  );

  logic unused_bits;
  assign unused_bits = ^{s_axil_awprot, s_axil_arprot, wr_addr[1:0], s_axil_araddr[1:0]};

  assign s_axil_awready = awready_q;
  assign s_axil_wready  = wready_q;
  assign s_axil_bvalid  = bvalid_q;
  assign s_axil_bresp   = bresp_q;
  assign s_axil_arready = arready_q;
  assign s_axil_rvalid  = rvalid_q;
  assign s_axil_rdata   = rdata_q;
  assign s_axil_rresp   = rresp_q;
  assign wr_state_o     = wr_state_q;
  assign rd_state_o     = rd_state_q;

endmodule
